top_encoder_16to4: RTL and testbench

TOP_ENCODER_16TO4 -- requirements
Module: top_encoder_16to4

---
 rtl/top_encoder_16to4.sv | 57 +++++
 tb/tb_top_encoder_16to4.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/top_encoder_16to4.sv
// Registered 16-to-4 priority encoder: highest set request bit wins, with valid flag.
// Optional multi-hot error flag (port err) is built when ONEHOT_CHK_EN is defined.
module top_encoder_16to4 #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] out,
`ifdef ONEHOT_CHK_EN
  output logic             err,
`endif
  output logic             valid
);

  logic [OUT_W-1:0] idx_c;
  logic             any_c;

  // Ascending scan so the highest-index set bit overrides lower ones.
  always_comb begin
    idx_c = '0;
    for (int i = 0; i < int'(IN_W); i++) begin
      if (in[i]) idx_c = OUT_W'(i);
    end
    any_c = |in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out   <= '0;
      valid <= 1'b0;
    end else if (en) begin
      out   <= idx_c;
      valid <= any_c;
    end
  end

`ifdef ONEHOT_CHK_EN
  logic multi_c;

  // Clearing the lowest set bit leaves something only when two or more bits are set.
  always_comb begin
    multi_c = |(in & (in - IN_W'(1)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (en) begin
      err <= multi_c;
    end
  end
`endif

endmodule

// File: tb/tb_top_encoder_16to4.sv
// Self-checking bench for top_encoder_16to4: directed cases plus randomized traffic
// against a behavioural model; err is checked when ONEHOT_CHK_EN is defined.
module tb_top_encoder_16to4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] in;
  logic [3:0]  out;
  logic        valid;
`ifdef ONEHOT_CHK_EN
  logic        err;
`endif

  int checks = 0;
  int errors = 0;

  logic [3:0] m_out;
  logic       m_valid;
  logic       m_err;

  always #5 clk = ~clk;

  top_encoder_16to4 #(.IN_W(16), .OUT_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .in    (in),
    .out   (out),
`ifdef ONEHOT_CHK_EN
    .err   (err),
`endif
    .valid (valid)
  );

  // Position of the most significant one, as floor(log2(v)); zero input maps to 0.
  function automatic int msb_index(logic [15:0] v);
    int unsigned x;
    int n;
    x = v;
    n = 0;
    while (x > 1) begin
      x = x / 2;
      n++;
    end
    return n;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(logic r, logic e, logic [15:0] v);
    if (r) begin
      m_out = 4'd0; m_valid = 1'b0; m_err = 1'b0;
    end else if (e) begin
      m_out   = 4'(msb_index(v));
      m_valid = (v != 16'h0);
      m_err   = ($countones(v) >= 2);
    end
  endtask

  task automatic compare(string tag);
    chk({tag, ".out"}, 32'(out), 32'(m_out));
    chk({tag, ".valid"}, 32'(valid), 32'(m_valid));
`ifdef ONEHOT_CHK_EN
    chk({tag, ".err"}, 32'(err), 32'(m_err));
`endif
  endtask

  // Drive on the falling edge, let one rising edge pass, sample 1 ns later.
  task automatic step(logic r, logic e, logic [15:0] v, string tag);
    @(negedge clk);
    rst = r; en = e; in = v;
    @(posedge clk);
    model_edge(r, e, v);
    #1;
    compare(tag);
  endtask

  initial begin
    logic [15:0] v;
    logic        r;
    logic        e;
    int          sel;

    rst = 1'b1; en = 1'b0; in = 16'h0;
    m_out = 4'd0; m_valid = 1'b0; m_err = 1'b0;

    step(1'b1, 1'b1, 16'hFFFF, "reset");
    chk("reset_out_const", 32'(out), 32'd0);

    // One-hot sweep
    for (int k = 0; k < 16; k++) begin
      v = 16'h1 << k;
      step(1'b0, 1'b1, v, "sweep");
      chk("sweep_idx", 32'(out), 32'(k));
      chk("sweep_valid", 32'(valid), 32'd1);
    end

    step(1'b0, 1'b1, 16'h0000, "zero");
    chk("zero_out", 32'(out), 32'd0);
    chk("zero_valid", 32'(valid), 32'd0);

    step(1'b0, 1'b1, 16'h8001, "prio");
    chk("prio_out", 32'(out), 32'd15);
`ifdef ONEHOT_CHK_EN
    chk("prio_err", 32'(err), 32'd1);
`endif

    step(1'b0, 1'b1, 16'h0012, "prio2");
    chk("prio2_out", 32'(out), 32'd4);

    // Hold while en is low
    step(1'b0, 1'b1, 16'h0400, "hold_load");
    chk("hold_load_out", 32'(out), 32'd10);
    step(1'b0, 1'b0, 16'h0008, "hold");
    chk("hold_out", 32'(out), 32'd10);
    step(1'b0, 1'b0, 16'h0000, "hold2");
    chk("hold2_valid", 32'(valid), 32'd1);

    // Mid-stream reset discards the sample, then sampling resumes
    step(1'b0, 1'b1, 16'h0400, "pre_rst");
    step(1'b1, 1'b1, 16'h0020, "rst_mid");
    chk("rst_mid_out", 32'(out), 32'd0);
    chk("rst_mid_valid", 32'(valid), 32'd0);
    step(1'b0, 1'b1, 16'h0020, "rst_rel");
    chk("rst_rel_out", 32'(out), 32'd5);

    // A reset pulse between edges has no effect
    @(negedge clk);
    en = 1'b1; in = 16'h0100; rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk);
    model_edge(1'b0, 1'b1, 16'h0100);
    #1;
    compare("rst_glitch");
    chk("rst_glitch_out", 32'(out), 32'd8);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      r   = ($urandom_range(0, 19) == 0);
      e   = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 3);
      case (sel)
        0:       v = 16'h0;
        1:       v = 16'h1 << $urandom_range(0, 15);
        2:       v = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
        default: v = 16'($urandom);
      endcase
      step(r, e, v, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
